// File: rtl/triangle_setup.sv
// Triangle setup: pops one triangle from the FIFO, computes doubled signed area and a
// screen-clamped bounding box, normalises winding, culls, and hands survivors downstream.
module triangle_setup #(
    parameter int WI       = 8,
    parameter int WF       = 8,
    parameter int SCREEN_W = 128,
    parameter int SCREEN_H = 128,
    parameter int XW       = 7,
    parameter int YW       = 7,
    parameter int AW       = 2 * (WI + WF) + 3
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         fifo_empty,
    output logic                         fifo_r_en,
    input  logic [2:0][2:0][WI+WF-1:0]   fifo_data,
    output logic                         tri_valid,
    input  logic                         tri_ready,
    output logic [2:0][2:0][WI+WF-1:0]   tri_vert,
    output logic [XW-1:0]                bbox_xmin,
    output logic [XW-1:0]                bbox_xmax,
    output logic [YW-1:0]                bbox_ymin,
    output logic [YW-1:0]                bbox_ymax,
    output logic [AW-1:0]                area2,
    output logic [15:0]                  tri_count,
    output logic [15:0]                  cull_count
);

    localparam int CW = WI + WF;
    localparam int EW = CW + 1;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] CAPT = 3'd2;
    localparam logic [2:0] DIFF = 3'd3;
    localparam logic [2:0] AREA = 3'd4;
    localparam logic [2:0] OUT  = 3'd5;

    function automatic logic signed [CW-1:0] floor_px(input logic signed [CW-1:0] v);
        return v >>> WF;
    endfunction

    // Only used on survivors, so a single [0, hi] clamp covers both min and max edges.
    function automatic int clamp_px(input logic signed [CW-1:0] f, input int hi);
        if (f[CW-1]) return 0;
        if (int'(f) > hi) return hi;
        return int'(f);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    function automatic logic signed [CW-1:0] min3(input logic signed [CW-1:0] a,
                                                  input logic signed [CW-1:0] b,
                                                  input logic signed [CW-1:0] c);
        logic signed [CW-1:0] m;
        m = (b < a) ? b : a;
        m = (c < m) ? c : m;
        return m;
    endfunction

    function automatic logic signed [CW-1:0] max3(input logic signed [CW-1:0] a,
                                                  input logic signed [CW-1:0] b,
                                                  input logic signed [CW-1:0] c);
        logic signed [CW-1:0] m;
        m = (b > a) ? b : a;
        m = (c > m) ? c : m;
        return m;
    endfunction

    logic [2:0] state;
    logic [2:0] next_state;

    logic [2:0][2:0][CW-1:0] vert_p0;
    logic signed [CW-1:0]    vx0, vx1, vx2, vy0, vy1, vy2;
    logic signed [EW-1:0]    e1x_p1, e1y_p1, e2x_p1, e2y_p1;
    logic signed [CW-1:0]    minx_p1, maxx_p1, miny_p1, maxy_p1;
    logic signed [AW-1:0]    e1x_w, e1y_w, e2x_w, e2y_w;
    logic signed [AW-1:0]    area_c;
    logic signed [CW-1:0]    fminx, fmaxx, fminy, fmaxy;
    logic                    offscreen;
    logic                    cull_c;
    logic                    neg_c;

    // CAPT: FIFO data is valid the cycle after the read strobe
    always_ff @(posedge Clk) begin
        if (state == CAPT) vert_p0 <= fifo_data;
    end

    assign vx0 = vert_p0[0][0];
    assign vy0 = vert_p0[0][1];
    assign vx1 = vert_p0[1][0];
    assign vy1 = vert_p0[1][1];
    assign vx2 = vert_p0[2][0];
    assign vy2 = vert_p0[2][1];

    // DIFF: edge vectors and extents
    always_ff @(posedge Clk) begin
        if (state == DIFF) begin
            e1x_p1  <= EW'(vx1) - EW'(vx0);
            e1y_p1  <= EW'(vy1) - EW'(vy0);
            e2x_p1  <= EW'(vx2) - EW'(vx0);
            e2y_p1  <= EW'(vy2) - EW'(vy0);
            minx_p1 <= min3(vx0, vx1, vx2);
            maxx_p1 <= max3(vx0, vx1, vx2);
            miny_p1 <= min3(vy0, vy1, vy2);
            maxy_p1 <= max3(vy0, vy1, vy2);
        end
    end

    // AREA: full-width cross product, then cull decision
    assign e1x_w  = AW'(e1x_p1);
    assign e1y_w  = AW'(e1y_p1);
    assign e2x_w  = AW'(e2x_p1);
    assign e2y_w  = AW'(e2y_p1);
    assign area_c = e1x_w * e2y_w - e2x_w * e1y_w;
    assign neg_c  = area_c[AW-1];

    assign fminx = floor_px(minx_p1);
    assign fmaxx = floor_px(maxx_p1);
    assign fminy = floor_px(miny_p1);
    assign fmaxy = floor_px(maxy_p1);

    assign offscreen = fmaxx[CW-1] || (int'(fminx) > SCREEN_W - 1) ||
                       fmaxy[CW-1] || (int'(fminy) > SCREEN_H - 1);
    assign cull_c    = (area_c == '0) || offscreen;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!fifo_empty) next_state = REQ;
            REQ:     next_state = CAPT;
            CAPT:    next_state = DIFF;
            DIFF:    next_state = AREA;
            AREA:    next_state = cull_c ? IDLE : OUT;
            OUT:     if (tri_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign fifo_r_en = (state == REQ);
    assign tri_valid = (state == OUT);

    // OUT: registered results held stable until accepted
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            tri_vert   <= '0;
            bbox_xmin  <= '0;
            bbox_xmax  <= '0;
            bbox_ymin  <= '0;
            bbox_ymax  <= '0;
            area2      <= '0;
            tri_count  <= '0;
            cull_count <= '0;
        end else begin
            state <= next_state;
            if (state == AREA && !cull_c) begin
                tri_vert[0] <= vert_p0[0];
                tri_vert[1] <= neg_c ? vert_p0[2] : vert_p0[1];
                tri_vert[2] <= neg_c ? vert_p0[1] : vert_p0[2];
                area2       <= neg_c ? -area_c : area_c;
                bbox_xmin   <= XW'(clamp_px(fminx, SCREEN_W - 1));
                bbox_xmax   <= XW'(clamp_px(fmaxx, SCREEN_W - 1));
                bbox_ymin   <= YW'(clamp_px(fminy, SCREEN_H - 1));
                bbox_ymax   <= YW'(clamp_px(fmaxy, SCREEN_H - 1));
            end
            if (state == AREA && cull_c) cull_count <= sat_inc(cull_count);
            if (state == OUT && tri_ready) tri_count <= sat_inc(tri_count);
        end
    end

endmodule

// File: tb/tb_triangle_setup.sv
// Self-checking bench for triangle_setup: FIFO model feeding the DUT, transfer monitor,
// and a plain-arithmetic reference model of area, winding, bbox and culling.
module tb_triangle_setup;

    localparam int AW = 35;
    typedef logic [2:0][2:0][15:0] tri_t;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          fifo_empty;
    logic          fifo_r_en;
    tri_t          fifo_data = '0;
    logic          tri_valid;
    logic          tri_ready = 1'b1;
    tri_t          tri_vert;
    logic [6:0]    bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
    logic [AW-1:0] area2;
    logic [15:0]   tri_count, cull_count;

    int total = 0;
    int bad = 0;

    triangle_setup dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en), .fifo_data(fifo_data),
        .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_vert(tri_vert),
        .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
        .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax),
        .area2(area2), .tri_count(tri_count), .cull_count(cull_count)
    );

    always #5 Clk = ~Clk;

    // FIFO model: data appears the cycle after the read strobe
    tri_t tri_mem [0:255];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge Clk) begin
        if (fifo_r_en) begin
            fifo_data <= tri_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Output monitor: records every completed handshake
    tri_t   got_vert [0:255];
    longint got_area [0:255];
    int     got_bx0 [0:255], got_bx1 [0:255], got_by0 [0:255], got_by1 [0:255];
    int     got_n = 0;
    always @(negedge Clk) begin
        if (tri_valid && tri_ready) begin
            got_vert[got_n] <= tri_vert;
            got_area[got_n] <= $signed(area2);
            got_bx0[got_n]  <= int'(bbox_xmin);
            got_bx1[got_n]  <= int'(bbox_xmax);
            got_by0[got_n]  <= int'(bbox_ymin);
            got_by1[got_n]  <= int'(bbox_ymax);
            got_n           <= got_n + 1;
        end
    end

    // Reference model results
    tri_t   exp_vert [0:255];
    longint exp_area [0:255];
    int     exp_bx0 [0:255], exp_bx1 [0:255], exp_by0 [0:255], exp_by1 [0:255];
    int     exp_n = 0;
    int     exp_cull = 0;
    int     tri_base = 0;

    function automatic int fl(input int v);
        int r;
        r = v % 256;
        if (r < 0) r += 256;
        return (v - r) / 256;
    endfunction

    function automatic void model(input tri_t t, output bit cull, output tri_t o,
                                  output longint a, output int bx0, output int bx1,
                                  output int by0, output int by1);
        longint x [3];
        longint y [3];
        int mnx, mxx, mny, mxy;
        for (int i = 0; i < 3; i++) begin
            x[i] = $signed(t[i][0]);
            y[i] = $signed(t[i][1]);
        end
        a = (x[1] - x[0]) * (y[2] - y[0]) - (x[2] - x[0]) * (y[1] - y[0]);
        mnx = fl(int'(x[0])); mxx = mnx;
        mny = fl(int'(y[0])); mxy = mny;
        for (int i = 1; i < 3; i++) begin
            if (fl(int'(x[i])) < mnx) mnx = fl(int'(x[i]));
            if (fl(int'(x[i])) > mxx) mxx = fl(int'(x[i]));
            if (fl(int'(y[i])) < mny) mny = fl(int'(y[i]));
            if (fl(int'(y[i])) > mxy) mxy = fl(int'(y[i]));
        end
        cull = (a == 0) || (mxx < 0) || (mnx > 127) || (mxy < 0) || (mny > 127);
        o = t;
        if (a < 0) begin
            o[1] = t[2];
            o[2] = t[1];
            a = -a;
        end
        bx0 = (mnx < 0) ? 0 : mnx;
        bx1 = (mxx > 127) ? 127 : mxx;
        by0 = (mny < 0) ? 0 : mny;
        by1 = (mxy > 127) ? 127 : mxy;
    endfunction

    function automatic tri_t mk(input int x0, input int y0, input int x1, input int y1,
                                input int x2, input int y2);
        tri_t t;
        t[0][0] = 16'(x0); t[0][1] = 16'(y0); t[0][2] = 16'h0001;
        t[1][0] = 16'(x1); t[1][1] = 16'(y1); t[1][2] = 16'h0002;
        t[2][0] = 16'(x2); t[2][1] = 16'(y2); t[2][2] = 16'h0003;
        return t;
    endfunction

    function automatic tri_t rnd_tri(input bit onscreen);
        tri_t t;
        for (int i = 0; i < 3; i++) begin
            t[i][0] = onscreen ? 16'($urandom_range(0, 30000)) : 16'(int'($urandom_range(0, 40000)) - 10000);
            t[i][1] = onscreen ? 16'($urandom_range(0, 30000)) : 16'(int'($urandom_range(0, 40000)) - 10000);
            t[i][2] = 16'($urandom);
        end
        if (!onscreen && $urandom_range(0, 7) == 0) t[2] = t[1];
        return t;
    endfunction

    task automatic push(input tri_t t);
        bit c; tri_t o; longint a; int bx0, bx1, by0, by1;
        tri_mem[wr_ptr] = t;
        wr_ptr = wr_ptr + 1;
        model(t, c, o, a, bx0, bx1, by0, by1);
        if (c) exp_cull++;
        else begin
            exp_vert[exp_n] = o; exp_area[exp_n] = a;
            exp_bx0[exp_n] = bx0; exp_bx1[exp_n] = bx1;
            exp_by0[exp_n] = by0; exp_by1[exp_n] = by1;
            exp_n++;
        end
    endtask

    task automatic drain();
        int c = 0;
        while (!(got_n == exp_n && int'(cull_count) == exp_cull && fifo_empty && !tri_valid) && c < 400) begin
            @(posedge Clk); #1;
            c++;
        end
        repeat (2) @(posedge Clk);
        #1;
        total++;
        if (c >= 400) begin
            bad++;
            $display("FAIL drain_timeout: got=%0d emitted, required=%0d; cull=%0d required=%0d",
                     got_n, exp_n, cull_count, exp_cull);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        total++;
        if (tri_valid !== 1'b0 || fifo_r_en !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl: valid=%b r_en=%b required 0 0", tri_valid, fifo_r_en);
        end
        total++;
        if (tri_vert !== '0 || area2 !== '0) begin
            bad++; $display("FAIL reset_data: vert=%h area=%h required 0", tri_vert, area2);
        end
        total++;
        if ({bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} !== 28'd0) begin
            bad++; $display("FAIL reset_bbox: %0d %0d %0d %0d required 0", bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax);
        end
        total++;
        if (tri_count !== 16'd0 || cull_count !== 16'd0) begin
            bad++; $display("FAIL reset_counts: tri=%0d cull=%0d required 0 0", tri_count, cull_count);
        end
        Reset_n = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_basic();
        tri_t a_t;
        int lat = -1;
        bit r1 = 0;
        a_t = mk(10*256, 10*256, 20*256, 10*256, 10*256, 20*256);
        tri_ready = 1'b1;
        push(a_t);
        for (int c = 1; c <= 8; c++) begin
            @(posedge Clk); #1;
            if (c == 1) r1 = fifo_r_en;
            if (tri_valid && lat < 0) lat = c;
        end
        total++;
        if (r1 !== 1'b1) begin bad++; $display("FAIL basic_r_en_cycle1: got=%b required 1", r1); end
        total++;
        if (lat != 5) begin bad++; $display("FAIL basic_latency: got=%0d required 5", lat); end
        drain();
        total++;
        if (got_vert[got_n-1] !== a_t || got_area[got_n-1] != 64'h640000) begin
            bad++; $display("FAIL basic_result: vert=%h area=%h required vert=%h area=640000",
                            got_vert[got_n-1], got_area[got_n-1], a_t);
        end
        total++;
        if (got_bx0[got_n-1] != 10 || got_bx1[got_n-1] != 20 || got_by0[got_n-1] != 10 || got_by1[got_n-1] != 20) begin
            bad++; $display("FAIL basic_bbox: %0d..%0d x %0d..%0d required 10..20 x 10..20",
                            got_bx0[got_n-1], got_bx1[got_n-1], got_by0[got_n-1], got_by1[got_n-1]);
        end
        total++;
        if (tri_count !== 16'd1) begin bad++; $display("FAIL basic_tri_count: got=%0d required 1", tri_count); end
    endtask

    task automatic test_winding();
        tri_t want;
        push(mk(10*256, 10*256, 10*256, 20*256, 20*256, 10*256));
        want = mk(10*256, 10*256, 20*256, 10*256, 10*256, 20*256);
        want[1][2] = 16'h0003;
        want[2][2] = 16'h0002;
        drain();
        total++;
        if (got_vert[got_n-1] !== want || got_area[got_n-1] != 64'h640000) begin
            bad++; $display("FAIL winding: vert=%h area=%h required vert=%h area=640000",
                            got_vert[got_n-1], got_area[got_n-1], want);
        end
    endtask

    task automatic test_cull_collinear();
        int rc [$];
        bit early_valid = 0;
        int g0 = got_n;
        push(mk(0, 0, 5*256, 5*256, 10*256, 10*256));
        push(mk(10*256, 10*256, 20*256, 10*256, 10*256, 20*256));
        for (int c = 1; c <= 12; c++) begin
            @(posedge Clk); #1;
            if (fifo_r_en) rc.push_back(c);
            if (tri_valid && c < 10) early_valid = 1;
        end
        total++;
        if (rc.size() < 2 || rc[0] != 1 || rc[1] != 6) begin
            bad++; $display("FAIL cull_reissue: r_en cycles=%p required {1,6}", rc);
        end
        total++;
        if (early_valid) begin bad++; $display("FAIL cull_no_valid: valid seen before cycle 10, required none"); end
        drain();
        total++;
        if (int'(cull_count) != 1 || got_n != g0 + 1) begin
            bad++; $display("FAIL cull_counts: cull=%0d emitted=%0d required 1 and %0d", cull_count, got_n - g0, 1);
        end
    endtask

    task automatic test_clamp();
        push(mk(-20*256, -5*256, 50*256, -5*256, -20*256, 40*256));
        drain();
        total++;
        if (got_bx0[got_n-1] != 0 || got_bx1[got_n-1] != 50 || got_by0[got_n-1] != 0 || got_by1[got_n-1] != 40) begin
            bad++; $display("FAIL clamp_bbox: %0d..%0d x %0d..%0d required 0..50 x 0..40",
                            got_bx0[got_n-1], got_bx1[got_n-1], got_by0[got_n-1], got_by1[got_n-1]);
        end
        total++;
        if (got_area[got_n-1] != longint'(3150) * 65536) begin
            bad++; $display("FAIL clamp_area: got=%0d required %0d", got_area[got_n-1], longint'(3150) * 65536);
        end
    endtask

    task automatic test_offscreen();
        int c0 = int'(cull_count);
        int g0 = got_n;
        push(mk(-30*256, 10*256, -10*256, 20*256, -128, 40*256));
        drain();
        total++;
        if (int'(cull_count) != c0 + 1 || got_n != g0) begin
            bad++; $display("FAIL offscreen_cull: cull=%0d emitted=%0d required %0d and 0", cull_count, got_n - g0, c0 + 1);
        end
        push(mk(-30*256, 10*256, -10*256, 20*256, 0, 40*256));
        drain();
        total++;
        if (got_n != g0 + 1 || got_bx0[got_n-1] != 0 || got_bx1[got_n-1] != 0 ||
            got_by0[got_n-1] != 10 || got_by1[got_n-1] != 40) begin
            bad++; $display("FAIL edge_bbox: emitted=%0d bbox %0d..%0d x %0d..%0d required 1, 0..0 x 10..40",
                            got_n - g0, got_bx0[got_n-1], got_bx1[got_n-1], got_by0[got_n-1], got_by1[got_n-1]);
        end
    endtask

    task automatic test_backpressure();
        tri_t t, o, s_vert;
        bit c;
        longint a;
        int bx0, bx1, by0, by1, w;
        logic [AW-1:0] s_area;
        logic [27:0] s_bb;
        int g0 = got_n;
        tri_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do begin
                t = rnd_tri(1'b1);
                model(t, c, o, a, bx0, bx1, by0, by1);
            end while (c);
            push(t);
        end
        w = 0;
        while (!tri_valid && w < 20) begin @(posedge Clk); #1; w++; end
        total++;
        if (!tri_valid) begin bad++; $display("FAIL bp_valid_timeout: valid=%b required 1", tri_valid); end
        s_vert = tri_vert; s_area = area2;
        s_bb = {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax};
        for (int k = 0; k < 10; k++) begin
            @(posedge Clk); #1;
            total++;
            if (tri_valid !== 1'b1 || fifo_r_en !== 1'b0 || tri_vert !== s_vert || area2 !== s_area ||
                {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} !== s_bb) begin
                bad++; $display("FAIL bp_hold cycle %0d: valid=%b r_en=%b area=%h required valid=1 r_en=0 area=%h",
                                k, tri_valid, fifo_r_en, area2, s_area);
            end
        end
        tri_ready = 1'b1;
        drain();
        total++;
        if (got_n != g0 + 3) begin bad++; $display("FAIL bp_count: emitted=%0d required 3", got_n - g0); end
        for (int i = g0; i < got_n; i++) begin
            total++;
            if (got_vert[i] !== exp_vert[i] || got_area[i] != exp_area[i] ||
                got_bx0[i] != exp_bx0[i] || got_bx1[i] != exp_bx1[i] ||
                got_by0[i] != exp_by0[i] || got_by1[i] != exp_by1[i]) begin
                bad++; $display("FAIL bp_order[%0d]: vert=%h area=%0d required vert=%h area=%0d",
                                i, got_vert[i], got_area[i], exp_vert[i], exp_area[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        tri_t a_t;
        a_t = mk(10*256, 10*256, 20*256, 10*256, 10*256, 20*256);
        tri_ready = 1'b1;
        push(a_t);
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        total++;
        if (tri_valid !== 1'b0 || fifo_r_en !== 1'b0 || tri_count !== 16'd0 || cull_count !== 16'd0 ||
            area2 !== '0 || tri_vert !== '0 || {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} !== 28'd0) begin
            bad++; $display("FAIL mid_reset: valid=%b tri=%0d cull=%0d area=%h required all 0",
                            tri_valid, tri_count, cull_count, area2);
        end
        exp_n = got_n;
        exp_cull = 0;
        tri_base = got_n;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        repeat (6) @(posedge Clk);
        #1;
        total++;
        if (got_n != tri_base || tri_valid !== 1'b0) begin
            bad++; $display("FAIL mid_reset_discard: emitted=%0d valid=%b required 0 0", got_n - tri_base, tri_valid);
        end
        push(a_t);
        drain();
        total++;
        if (got_vert[got_n-1] !== a_t || got_area[got_n-1] != 64'h640000 || tri_count !== 16'd1) begin
            bad++; $display("FAIL post_reset: vert=%h area=%h tri=%0d required vert=%h area=640000 tri=1",
                            got_vert[got_n-1], got_area[got_n-1], tri_count, a_t);
        end
    endtask

    task automatic test_random();
        int g0 = got_n;
        int cyc = 0;
        bit pv, pr;
        tri_t pvert;
        logic [AW-1:0] parea;
        for (int k = 0; k < 40; k++) push(rnd_tri(1'b0));
        pv = 0; pr = 0; pvert = '0; parea = '0;
        while (!(got_n == exp_n && int'(cull_count) == exp_cull && fifo_empty) && cyc < 3000) begin
            @(posedge Clk); #1;
            if (pv && !pr) begin
                total++;
                if (tri_valid !== 1'b1 || tri_vert !== pvert || area2 !== parea) begin
                    bad++; $display("FAIL rand_hold: valid=%b area=%h required valid=1 area=%h", tri_valid, area2, parea);
                end
            end
            tri_ready = 1'($urandom_range(0, 1));
            pv = tri_valid; pr = tri_ready; pvert = tri_vert; parea = area2;
            cyc++;
        end
        tri_ready = 1'b1;
        drain();
        for (int i = g0; i < got_n; i++) begin
            total++;
            if (got_vert[i] !== exp_vert[i] || got_area[i] != exp_area[i] ||
                got_bx0[i] != exp_bx0[i] || got_bx1[i] != exp_bx1[i] ||
                got_by0[i] != exp_by0[i] || got_by1[i] != exp_by1[i]) begin
                bad++; $display("FAIL rand[%0d]: vert=%h area=%0d bbox %0d..%0d x %0d..%0d required vert=%h area=%0d bbox %0d..%0d x %0d..%0d",
                                i, got_vert[i], got_area[i], got_bx0[i], got_bx1[i], got_by0[i], got_by1[i],
                                exp_vert[i], exp_area[i], exp_bx0[i], exp_bx1[i], exp_by0[i], exp_by1[i]);
            end
        end
        total++;
        if (int'(tri_count) != exp_n - tri_base || int'(cull_count) != exp_cull) begin
            bad++; $display("FAIL rand_counts: tri=%0d cull=%0d required %0d %0d",
                            tri_count, cull_count, exp_n - tri_base, exp_cull);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_winding();
        test_cull_collinear();
        test_clamp();
        test_offscreen();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/triangle_setup.md
# triangle_setup

Downstream consumer of the on-chip triangle FIFO. It pops one triangle at a time and computes the doubled signed area. It normalises winding to positive area, computes a screen-clamped integer bounding box, and culls degenerate or fully off-screen triangles. Surviving triangles go to the rasterizer over a valid/ready handshake.

## Interface
- WI, 8: integer bits of signed fixed-point coordinate.
- WF, 8: fraction bits of coordinate.
- SCREEN_W, 128: screen width in pixels.
- SCREEN_H, 128: screen height in pixels.
- XW, 7: bbox x width, must satisfy 2^XW ≥ SCREEN_W.
- YW, 7: bbox y width, must satisfy 2^YW ≥ SCREEN_H.
- AW: derived parameter, equal to 2*(WI+WF)+3. Width of the area result.
- Clk  in  1  single clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  FIFO is_empty.
- fifo_r_en  out  1  FIFO read enable.
- fifo_data  in  [2:0][2:0][WI+WF-1:0]  FIFO triangle_out. Index order is [vertex][coord], with coord 0=x, 1=y, 2=z. Values are two's complement QWI.WF.
- tri_valid  out  1  output triangle valid.
- tri_ready  in  1  rasterizer accepts.
- tri_vert  out  [2:0][2:0][WI+WF-1:0]  reordered vertices.
- bbox_xmin, bbox_xmax  out  XW  inclusive pixel columns.
- bbox_ymin, bbox_ymax  out  YW  inclusive pixel rows.
- area2  out  AW  signed doubled area, scaled by 2^(2WF). Always > 0 when tri_valid is high.
- tri_count  out  16  triangles emitted. Saturates at 0xFFFF.
- cull_count  out  16  triangles culled. Saturates at 0xFFFF.

## Operation
- FSM states: IDLE, REQ, CAPT, DIFF, AREA, OUT. Only one triangle is in flight at a time.
- IDLE: if fifo_empty=0, go to REQ.
- REQ: fifo_r_en=1 for exactly this cycle, decoded from state. Go to CAPT.
- CAPT: register fifo_data, which is valid in the cycle after r_en. Go to DIFF.
- DIFF:
  - Compute e1=v1−v0 and e2=v2−v0 for x and y, each WI+WF+1 bits signed.
  - Compute min and max of x and y over the three vertices.
  - Go to AREA.
- AREA: compute area2 = e1x·e2y − e2x·e1y at full AW width, with no truncation. Then evaluate, in this order:
  - area2 == 0: cull.
  - floor(maxx) < 0, or floor(minx) > SCREEN_W−1, or the same test on y: cull.
  - Otherwise go to OUT.
  - On cull: increment cull_count (saturating) and return to IDLE.
- Floor: arithmetic shift right by WF. For example, −0.5 floors to −1.
- Clamp:
  - bbox_xmin = max(floor(minx), 0) and bbox_xmax = min(floor(maxx), SCREEN_W−1).
  - The same rule applies to y, using SCREEN_H−1.
- Winding: if area2 < 0, output vertices in the order v0,v2,v1 and output −area2. Otherwise output v0,v1,v2 and area2 unchanged. The z coordinate travels with its vertex.
- OUT:
  - tri_valid=1, with all tri_*/bbox_*/area2 outputs registered and stable.
  - On tri_valid&&tri_ready: increment tri_count (saturating) and go to IDLE.
  - No FIFO read is issued while in OUT.

## Timing
- Reset values:
  - State is IDLE.
  - fifo_r_en=0, tri_valid=0.
  - tri_vert, bbox_*, area2, tri_count and cull_count are all 0.
- Reset is asynchronous: assertion takes effect immediately, including mid-triangle. A popped triangle is discarded, counters clear, and no tri_valid is emitted.
- Latency: with IDLE in cycle 0 and fifo_empty=0, fifo_r_en is high in cycle 1 and tri_valid rises in cycle 5.
- Throughput: at best one triangle per 6 cycles, counting IDLE.
- A culled triangle returns to IDLE in cycle 5.
- The handshake completes on any edge where tri_valid and tri_ready are both 1.
  - tri_ready may be held high permanently.
  - tri_valid never drops without a transfer, except on reset.
- fifo_empty is sampled only in IDLE, so a read is never issued to an empty FIFO.
- The FIFO is drained in order, and triangle order is preserved on the output.

## Test plan
- Q8.8 input (10,10),(20,10),(10,20) -> tri_valid in cycle 5 with vertex order unchanged. bbox 10..20 by 10..20, area2=100·2^16=0x640000, tri_count=1.
- Input (10,10),(10,20),(20,10), which has negative area -> tri_vert order is (10,10),(20,10),(10,20), area2=0x640000.
- Collinear (0,0),(5,5),(10,10) -> no tri_valid, cull_count=1, FSM in IDLE by cycle 5.
- (−20,−5),(50,−5),(−20,40) -> bbox x 0..50, y 0..40, area2=3150·2^16.
- Triangle with x={−30,−10,−0.5} -> culled as off-screen, cull_count increments. The same triangle with one x=0.0 -> emitted with bbox_xmin=bbox_xmax=0.
- Backpressure and reset:
  - Three triangles queued, tri_ready held low 10 cycles on the first -> output stable, fifo_r_en stays 0, all three are emitted in order.
  - Reset_n pulsed low in DIFF -> all outputs 0 immediately, and the next triangle is processed normally.
